d_grf_wport_arb: RTL and testbench
==================================

// Module: d_grf_wport_arb
// PURPOSE
//  Shares the single GRF write port (regDst/regWd/pc) between the W-stage writeback and
//  the multi-cycle unit (MDU/late-result path).
//  The W stage always wins and is never stalled. The MDU side uses a valid/ready handshake.
//  A starvation counter raises stall_req so the pipeline inserts bubbles and the MDU write drains.
//  Sits between W stage, MDU and d_grf. Its stall_req feeds the D-stage hazard unit.
// PARAMETERS
//  STARVE_MAX  4   consecutive blocked cycles before stall_req asserts (1..15)
//  CNT_W       4   width of starvation counter; must hold STARVE_MAX
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset (0 = reset)
//  w_en       in   1   W stage has a writeback this cycle
//  w_addr     in   5   W-stage destination register
//  w_data     in   32  W-stage write data
//  w_pc       in   32  W-stage instruction PC (for GRF write log)
//  mdu_valid  in   1   MDU write request pending
//  mdu_addr   in   5   MDU destination register
//  mdu_data   in   32  MDU write data
//  mdu_pc     in   32  PC of instruction that issued the MDU op
//  mdu_ready  out  1   MDU request accepted this cycle (combinational)
//  regDst     out  5   GRF write address; 0 = no write
//  regWd      out  32  GRF write data
//  pc         out  32  PC driven to GRF with the write
//  stall_req  out  1   registered; pipeline must hold F/D and send bubbles to E
//  mdu_pend   out  1   mdu_valid && !mdu_ready; hazard unit blocks readers of mdu_addr
// BEHAVIOUR
//  - w_act = w_en && (w_addr != 0). A W write to $0 counts as idle.
//  - Datapath mux is combinational with zero added latency. GRF writes on the same clk edge.
//    - w_act: regDst=w_addr, regWd=w_data, pc=w_pc, mdu_ready=0.
//    - else mdu_valid: regDst=mdu_addr, regWd=mdu_data, pc=mdu_pc, mdu_ready=1.
//    - else: regDst=0, regWd=0, pc=0, mdu_ready=0.
//  - Handshake: transfer when mdu_valid && mdu_ready.
//    - MDU holds addr/data/pc stable while valid && !ready. Valid never drops before transfer.
//    - A new request may follow in the very next cycle.
//    - mdu_addr==0 is accepted and discarded, since regDst=0 means no write.
//  - FSM (registered state, cnt, stall_req):
//    - IDLE: mdu_valid && w_act -> WAIT with cnt=1. Otherwise stay in IDLE.
//    - WAIT: on transfer -> IDLE, cnt=0.
//      - If still blocked: cnt++. When cnt reaches STARVE_MAX, go to STALL and set stall_req=1.
//    - STALL: stall_req=1 and cnt frozen. On transfer -> IDLE, next-edge stall_req=0, cnt=0.
//  - stall_req rises on the edge after the STARVE_MAX-th blocked cycle.
//    It falls on the edge that completes the transfer. Its max width is pipeline depth + 1.
//  - mdu_valid dropping in WAIT/STALL is a protocol violation. RTL returns to IDLE and clears cnt/stall_req.
//  - Simultaneous w_act and transfer cannot happen: W has strict priority.
//  - WAR/WAW ordering between W and MDU to the same register belongs to the hazard unit, via mdu_pend.
//  - Reset (async, any state): state=IDLE, cnt=0, stall_req=0. Combinational outputs follow inputs.
//    An in-flight request is not lost and is re-accepted after reset release if valid is still high.
// TESTING
//  1 reset=0 mid-STALL -> stall_req=0 immediately.
//    Release with w_en=0, mdu_valid=1, addr=5 -> first cycle mdu_ready=1, regDst=5.
//  2 w_en=1, w_addr=3, w_data=32'h1234; mdu_valid=0 -> regDst=3, regWd=32'h1234, pc=w_pc, mdu_ready=0.
//  3 mdu_valid=1, addr=8, data=32'hCAFE; w_en=1 for 2 cycles then 0 -> mdu_ready=0 for 2 cycles.
//    Then regDst=8, regWd=32'hCAFE. stall_req stays 0.
//  4 STARVE_MAX=4; w_en=1 continuously with mdu pending -> stall_req=1 after 4th edge.
//    Drop w_en -> same cycle mdu_ready=1, next edge stall_req=0.
//  5 w_en=1, w_addr=0 with mdu_valid=1, addr=9 -> MDU granted (regDst=9), no $0 write.
//    mdu_addr=0 with W idle -> mdu_ready=1, regDst=0.
//  6 Back-to-back MDU requests (addr 1, 2) with W idle -> regDst=1 then 2 on consecutive cycles.

Source files
------------

// File: rtl/d_grf_wport_arb.sv
// d_grf_wport_arb: shares the single GRF write port between W-stage writeback
// and the multi-cycle unit. The W stage always wins and is never stalled. The
// MDU side uses a valid/ready handshake. A starvation counter raises stall_req
// so the pipeline inserts bubbles and the pending MDU write can drain.
module d_grf_wport_arb #(
  parameter int unsigned STARVE_MAX = 4,  // blocked cycles before stall_req (1..15)
  parameter int unsigned CNT_W      = 4   // must be wide enough to hold STARVE_MAX
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic        w_en,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic [31:0] w_pc,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic [31:0] mdu_pc,
  output logic        mdu_ready,
  output logic [4:0]  regDst,
  output logic [31:0] regWd,
  output logic [31:0] pc,
  output logic        stall_req,
  output logic        mdu_pend
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STALL
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             w_act;
  logic             blocked;

  // A W-stage write to $0 is no write at all, so it must not block the MDU.
  assign w_act   = w_en && (w_addr != 5'd0);
  // The MDU wants the port this cycle but W owns it.
  assign blocked = mdu_valid && w_act;
  assign cnt_inc = cnt + CNT_W'(1);

  // Write-port mux: W has strict priority, MDU takes any idle cycle.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the if-chain
    // can leave one unassigned and infer a latch.
    regDst    = 5'd0;
    regWd     = 32'd0;
    pc        = 32'd0;
    mdu_ready = 1'b0;
    if (w_act) begin
      regDst = w_addr;
      regWd  = w_data;
      pc     = w_pc;
    end else if (mdu_valid) begin
      regDst    = mdu_addr;
      regWd     = mdu_data;
      pc        = mdu_pc;
      mdu_ready = 1'b1;
    end
  end

  // The hazard unit must hold readers of mdu_addr while the write is still in flight.
  assign mdu_pend = mdu_valid && !mdu_ready;

  // Starvation tracker: counts consecutive blocked cycles and raises stall_req.
  // Any unblocked cycle returns to IDLE. That cycle is either the transfer or
  // an illegal drop of mdu_valid.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      stall_req <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (blocked) begin
            cnt <= cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              state     <= ST_STALL;
              stall_req <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stall_req <= 1'b0;
          end
        end
        ST_STALL: begin
          // Counter frozen while stalled. Leave as soon as W yields the port.
          if (!blocked) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stall_req <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          stall_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_grf_wport_arb.sv
// Testbench for d_grf_wport_arb. The stimulus side drives one cycle at a time
// and pushes the expected per-cycle response, plus every issued MDU request,
// into queues. A monitor on the falling edge pops and compares the queued
// values against the DUT outputs.
module tb_d_grf_wport_arb;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] w_pc;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic [31:0] mdu_pc;
  logic        mdu_ready;
  logic [4:0]  regDst;
  logic [31:0] regWd;
  logic [31:0] pc;
  logic        stall_req;
  logic        mdu_pend;

  d_grf_wport_arb #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_pc(w_pc),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_pc(mdu_pc),
    .mdu_ready(mdu_ready), .regDst(regDst), .regWd(regWd), .pc(pc),
    .stall_req(stall_req), .mdu_pend(mdu_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        ready;
    logic        pend;
    logic        stall;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } req_t;

  exp_t exp_q[$];
  req_t mdu_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: the length of the current run of consecutive
  // blocked cycles, and whether the last driven cycle completed a transfer.
  int   run_len   = 0;
  logic last_xfer = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one clock cycle of stimulus and queue what the DUT must show for it.
  task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] wp,
                       input logic nreq, input logic [4:0] ma,
                       input logic [31:0] md, input logic [31:0] mp);
    exp_t e;
    logic wact;
    @(posedge clk);
    #1;
    if (last_xfer) mdu_valid = 1'b0;
    if (nreq && !mdu_valid) begin
      mdu_valid = 1'b1;
      mdu_addr  = ma;
      mdu_data  = md;
      mdu_pc    = mp;
      mdu_q.push_back('{addr: ma, data: md, pc: mp});
    end
    reset  = rst;
    w_en   = we;
    w_addr = wa;
    w_data = wd;
    w_pc   = wp;

    wact    = we && (wa != 5'd0);
    e.stall = rst && (run_len >= STARVE_MAX);
    if (wact) begin
      e.dst = wa; e.wd = wd; e.pc = wp; e.ready = 1'b0;
    end else if (mdu_valid) begin
      e.dst = mdu_addr; e.wd = mdu_data; e.pc = mdu_pc; e.ready = 1'b1;
    end else begin
      e.dst = 5'd0; e.wd = 32'd0; e.pc = 32'd0; e.ready = 1'b0;
    end
    e.pend = mdu_valid && !e.ready;
    run_len   = (rst && mdu_valid && wact) ? run_len + 1 : 0;
    last_xfer = rst && mdu_valid && !wact;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  // Random traffic in 16-cycle segments with a varying W-stage duty, so that
  // light, heavy and fully starving phases all occur.
  task automatic run_random(input int segs);
    int          duty;
    logic        we;
    logic [4:0]  wa;
    logic        nreq;
    logic [4:0]  ma;
    for (int s = 0; s < segs; s++) begin
      case ($urandom_range(3))
        0:       duty = 0;
        1:       duty = 50;
        2:       duty = 90;
        default: duty = 100;
      endcase
      for (int k = 0; k < 16; k++) begin
        we   = ($urandom_range(99) < duty);
        wa   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
        nreq = ($urandom_range(99) < 60);
        ma   = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
        cycle(1'b1, we, wa, $urandom(), $urandom(), nreq, ma, $urandom(), $urandom());
      end
    end
  endtask

  // Monitor: compares each queued cycle, and matches every observed transfer
  // against the oldest outstanding MDU request.
  always @(negedge clk) begin
    exp_t e;
    req_t r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("regDst",    32'(regDst),    32'(e.dst));
      check("regWd",     regWd,          e.wd);
      check("pc",        pc,             e.pc);
      check("mdu_ready", 32'(mdu_ready), 32'(e.ready));
      check("mdu_pend",  32'(mdu_pend),  32'(e.pend));
      check("stall_req", 32'(stall_req), 32'(e.stall));
    end
    if (reset && mdu_valid && mdu_ready) begin
      if (mdu_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: transfer seen with no outstanding request at %0t", $time);
      end else begin
        r = mdu_q.pop_front();
        check("xfer_addr", 32'(regDst), 32'(r.addr));
        check("xfer_data", regWd,       r.data);
        check("xfer_pc",   pc,          r.pc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    w_en      = 1'b0;
    w_addr    = 5'd0;
    w_data    = 32'd0;
    w_pc      = 32'd0;
    mdu_valid = 1'b0;
    mdu_addr  = 5'd0;
    mdu_data  = 32'd0;
    mdu_pc    = 32'd0;

    // Reset state, then release with everything idle.
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    idle(1);

    // W-only write.
    cycle(1'b1, 1'b1, 5'd3, 32'h1234, 32'h400, 1'b0, 5'd0, 32'd0, 32'd0);

    // MDU blocked for two cycles, then granted; no stall.
    cycle(1'b1, 1'b1, 5'd4, 32'h11, 32'h404, 1'b1, 5'd8, 32'hCAFE, 32'h500);
    cycle(1'b1, 1'b1, 5'd6, 32'h22, 32'h408, 1'b0, 5'd0, 32'd0, 32'd0);
    idle(2);

    // Full starvation: stall after the 4th blocked edge, clears after the transfer.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b1, 5'(i + 1), 32'(i), 32'h600 + 32'(i), 1'b1, 5'd10, 32'hBEEF, 32'h700);
    idle(2);

    // W write to $0 does not block; MDU write to $0 is accepted and discarded.
    cycle(1'b1, 1'b1, 5'd0, 32'hDEAD, 32'h800, 1'b1, 5'd9, 32'h99, 32'h804);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'h77, 32'h808);
    idle(1);

    // Back-to-back MDU requests with W idle.
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd1, 32'hA1, 32'h900);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd2, 32'hA2, 32'h904);
    idle(1);

    // Reset asserted mid-STALL drops stall_req at once; the pending request
    // survives and is granted on the first cycle after release.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b1, 5'd7, 32'h70, 32'hA00, 1'b1, 5'd5, 32'h55, 32'hA04);
    cycle(1'b0, 1'b1, 5'd7, 32'h70, 32'hA00, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    check("stall_async_reset", 32'(stall_req), 32'd0);
    cycle(1'b0, 1'b1, 5'd7, 32'h70, 32'hA00, 1'b0, 5'd0, 32'd0, 32'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    idle(1);

    run_random(120);

    idle(3);
    @(negedge clk);
    #1;
    check("mdu_q_drained", 32'(mdu_q.size()), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
